// File: rtl/aes256_top.sv
// aes256_top: iterative AES-256 encryption core, one round per clock,
// round keys generated on the fly from a 256-bit sliding window.
// Optional feature macro: AES_CTR_EN (counter mode; default build is ECB).
module aes256_top (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [127:0] plaintext_i,
    input  logic [255:0] key_i,
    output logic [127:0] ciphertext_o,
    output logic         done_o,
    output logic         busy_o
);

    localparam int unsigned NR = 14;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [255:0] kwin_q, kwin_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] ct_q, ct_d;
    logic         done_q, done_d;
    logic         busy_q, busy_d;
`ifdef AES_CTR_EN
    logic [127:0] ctr_q, ctr_d;
    logic [127:0] pt_q, pt_d;
`endif

    logic [7:0]   sb_c [16];
    logic [127:0] sr_c;
    logic [127:0] mc_c;
    logic [127:0] rnd_out_c;
    logic [7:0]   rcon_c;
    logic [31:0]  ktemp_c;
    logic [127:0] knew_c;
    logic [127:0] rkey_c;
    logic [127:0] src_c;
    logic [127:0] result_c;

    // Round datapath: SubBytes, ShiftRows, MixColumns (skipped in the last round), AddRoundKey.
    always_comb begin
        sr_c = '0;
        mc_c = '0;
        for (int k = 0; k < 16; k++) begin
            sb_c[k] = sbox(state_q[127 - 8*k -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_c[127 - 8*(4*c + r) -: 8] = sb_c[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc_c[127 - 32*c -: 32] = mix_col(sr_c[127 - 32*c -: 32]);
        end
        rnd_out_c = ((round_q == 4'(NR)) ? sr_c : mc_c) ^ rkey_c;
    end

    // Key schedule: next four words from the window; even blocks rotate and add Rcon.
    always_comb begin
        rcon_c  = 8'h01 << (round_q[3:1] - 3'd1);
        ktemp_c = round_q[0] ? sub_word(kwin_q[31:0])
                             : (sub_word({kwin_q[23:0], kwin_q[31:24]}) ^ {rcon_c, 24'h000000});
        knew_c[127:96] = kwin_q[255:224] ^ ktemp_c;
        knew_c[95:64]  = kwin_q[223:192] ^ knew_c[127:96];
        knew_c[63:32]  = kwin_q[191:160] ^ knew_c[95:64];
        knew_c[31:0]   = kwin_q[159:128] ^ knew_c[63:32];
        // Round 1 uses the second key half directly; later rounds use freshly generated words.
        rkey_c = (round_q == 4'd1) ? kwin_q[127:0] : knew_c;
    end

    // Block source and final output combine for the selected mode.
    always_comb begin
`ifdef AES_CTR_EN
        src_c    = ctr_q;
        result_c = rnd_out_c ^ pt_q;
`else
        src_c    = plaintext_i;
        result_c = rnd_out_c;
`endif
    end

    // Control FSM and next-state for all registers.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        kwin_d  = kwin_q;
        round_d = round_q;
        ct_d    = ct_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef AES_CTR_EN
        ctr_d   = ctr_q;
        pt_d    = pt_q;
`endif
        case (fsm_q)
            ST_IDLE: begin
                if (en_i) begin
                    fsm_d   = ST_RUN;
                    kwin_d  = key_i;
                    state_d = src_c ^ key_i[255:128];
                    round_d = 4'd1;
                    busy_d  = 1'b1;
`ifdef AES_CTR_EN
                    pt_d    = plaintext_i;
`endif
                end
            end
            ST_RUN: begin
                state_d = rnd_out_c;
                round_d = round_q + 4'd1;
                if (round_q != 4'd1) begin
                    kwin_d = {kwin_q[127:0], knew_c};
                end
                if (round_q == 4'(NR)) begin
                    fsm_d   = ST_IDLE;
                    round_d = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ct_d    = result_c;
`ifdef AES_CTR_EN
                    ctr_d   = ctr_q + 128'd1;
`endif
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            kwin_q  <= '0;
            round_q <= '0;
            ct_q    <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            kwin_q  <= kwin_d;
            round_q <= round_d;
            ct_q    <= ct_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

`ifdef AES_CTR_EN
    // Counter block and latched plaintext for counter mode.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            ctr_q <= '0;
            pt_q  <= '0;
        end else begin
            ctr_q <= ctr_d;
            pt_q  <= pt_d;
        end
    end
`endif

    assign ciphertext_o = ct_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_aes256_top.sv
// Bench for aes256_top: randomized blocks against a GF(2^8)-arithmetic AES-256 model,
// plus known-answer vectors, latency, mid-op input change, reset abort and back-to-back.
module tb_aes256_top;

    logic         clk_i = 1'b0;
    logic         rst_n;
    logic         en_i;
    logic [127:0] plaintext_i;
    logic [255:0] key_i;
    logic [127:0] ciphertext_o;
    logic         done_o;
    logic         busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sb_ref [256];
    logic [127:0] ctr_m = '0;

    always #5 clk_i = ~clk_i;

    aes256_top dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .plaintext_i  (plaintext_i),
        .key_i        (key_i),
        .ciphertext_o (ciphertext_o),
        .done_o       (done_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [31:0] sub32(input logic [31:0] w);
        return {sb_ref[w[31:24]], sb_ref[w[23:16]], sb_ref[w[15:8]], sb_ref[w[7:0]]};
    endfunction

    // S-box from multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook AES-256: full key expansion, then state as a 4x4 byte matrix.
    function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] out;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = sub32({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = sub32(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
        for (int rnd = 1; rnd <= 14; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb_ref[s[r][c]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = t[r][(c + r) % 4];
            if (rnd < 14) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        t[r][c] = gmul(8'h02, s[r][c]) ^ gmul(8'h03, s[(r+1)%4][c])
                                ^ s[(r+2)%4][c] ^ s[(r+3)%4][c];
                s = t;
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = s[r][c] ^ w[4*rnd + c][31 - 8*r -: 8];
        end
        out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127 - 8*(4*c + r) -: 8] = s[r][c];
        return out;
    endfunction

    // Expected block result for the compiled mode; counter advances per completion.
    function automatic logic [127:0] expect_next(input logic [255:0] key, input logic [127:0] pt);
        logic [127:0] r;
`ifdef AES_CTR_EN
        r = aes_ref(key, ctr_m) ^ pt;
        ctr_m = ctr_m + 128'd1;
`else
        r = aes_ref(key, pt);
`endif
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block: start, optionally disturb inputs at round 5, check latency/busy/result.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [255:0] key,
                             input bit scramble, input bit use_fixed, input logic [127:0] fixed_ct);
        logic [127:0] exp;
        int lat;
        int busy_n;
        bit seen;
        exp = expect_next(key, pt);
        @(negedge clk_i);
        en_i = 1'b1;
        plaintext_i = pt;
        key_i = key;
        @(posedge clk_i);
        @(negedge clk_i);
        en_i = 1'b0;
        lat = 0;
        busy_n = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (busy_o) busy_n++;
            if (scramble && lat == 5) begin
                en_i = 1'b1;
                plaintext_i = rnd128();
                key_i = ~key_i;
            end else begin
                en_i = 1'b0;
            end
            @(posedge clk_i);
            lat++;
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        en_i = 1'b0;
        check({tag, " latency"}, 128'(lat), 128'(14));
        check({tag, " busy cycles"}, 128'(busy_n), 128'(14));
        check({tag, " busy at done"}, 128'(busy_o), 128'(0));
        check({tag, " ct model"}, ciphertext_o, exp);
        if (use_fixed) check({tag, " ct vector"}, ciphertext_o, fixed_ct);
        @(negedge clk_i);
        check({tag, " done width"}, 128'(done_o), 128'(0));
        check({tag, " ct held"}, ciphertext_o, exp);
    endtask

    task automatic reset_mid_op();
        int pulses;
        @(negedge clk_i);
        en_i = 1'b1;
        plaintext_i = rnd128();
        key_i = {rnd128(), rnd128()};
        @(posedge clk_i);
        @(negedge clk_i);
        en_i = 1'b0;
        repeat (7) @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        ctr_m = '0;
        check("abort busy", 128'(busy_o), 128'(0));
        check("abort done", 128'(done_o), 128'(0));
        check("abort ct", ciphertext_o, 128'(0));
        pulses = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (done_o) pulses++;
        end
        check("abort no done", 128'(pulses), 128'(0));
    endtask

    task automatic back_to_back();
        logic [127:0] pt1, pt2, e1, e2;
        logic [255:0] k1, k2;
        int t_done [$];
        logic [127:0] ct_seen [$];
        pt1 = rnd128();
        pt2 = rnd128();
        k1 = {rnd128(), rnd128()};
        k2 = {rnd128(), rnd128()};
        e1 = expect_next(k1, pt1);
        e2 = expect_next(k2, pt2);
        @(negedge clk_i);
        en_i = 1'b1;
        plaintext_i = pt1;
        key_i = k1;
        @(posedge clk_i);
        @(negedge clk_i);
        plaintext_i = pt2;
        key_i = k2;
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (done_o) begin
                t_done.push_back(cyc);
                ct_seen.push_back(ciphertext_o);
            end
            if (cyc == 15) en_i = 1'b0;
        end
        check("b2b pulse count", 128'(t_done.size()), 128'(2));
        if (t_done.size() == 2) begin
            check("b2b t1", 128'(t_done[0]), 128'(14));
            check("b2b t2", 128'(t_done[1]), 128'(29));
            check("b2b ct1", ct_seen[0], e1);
            check("b2b ct2", ct_seen[1], e2);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en_i = 1'b0;
        plaintext_i = '0;
        key_i = '0;
        build_sbox();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset ct", ciphertext_o, 128'(0));
        check("reset done", 128'(done_o), 128'(0));
        check("reset busy", 128'(busy_o), 128'(0));
        rst_n = 1'b1;

        run_block("zero", 128'h0, 256'h0, 1'b0, 1'b1, 128'hdc95c078a2408989ad48a21492842087);
`ifndef AES_CTR_EN
        run_block("fips", 128'h00112233445566778899aabbccddeeff,
                  256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  1'b0, 1'b1, 128'h8ea2b7ca516745bfeafc49904b496089);
`else
        run_block("ctr1", 128'h0, 256'h0, 1'b0, 1'b0, 128'h0);
`endif
        for (int i = 0; i < 6; i++) begin
            run_block($sformatf("rand%0d", i), rnd128(), {rnd128(), rnd128()},
                      (i % 2) == 1, 1'b0, 128'h0);
        end
        reset_mid_op();
        back_to_back();
        run_block("post", rnd128(), {rnd128(), rnd128()}, 1'b1, 1'b0, 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
